// File: rtl/fp_fma_dot_sequencer.sv
// Dot-product sequencer that feeds an external combinational FMA one element at a time.
// It accumulates acc = init + sum(a[i]*b[i]) and ORs the FMA exception flags into a sticky set.
module fp_fma_dot_sequencer #(
  parameter int exp_width  = 8,
  parameter int frac_width = 23,
  parameter int cnt_width  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [exp_width+frac_width:0]       init_acc,
  input  logic [1:0]                          round_mode,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [exp_width+frac_width:0]       in_a,
  input  logic [exp_width+frac_width:0]       in_b,
  input  logic                                in_last,
  output logic [exp_width+frac_width:0]       fma_op1,
  output logic [exp_width+frac_width:0]       fma_op2,
  output logic [exp_width+frac_width:0]       fma_op_acc,
  output logic [1:0]                          fma_round_mode,
  input  logic [exp_width+frac_width:0]       fma_result,
  input  logic [4:0]                          fma_exception,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [exp_width+frac_width:0]       out_result,
  output logic [4:0]                          out_exception,
  output logic [cnt_width-1:0]                out_count
);
  localparam int W = exp_width + frac_width + 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, EXEC, DONE} state_t;

  state_t               state_reg, state_next;
  logic [W-1:0]         acc_reg;
  logic [W-1:0]         op1_reg, op2_reg, op_acc_reg;
  logic [1:0]           mode_reg;
  logic [4:0]           sticky_reg, sticky_next;
  logic [cnt_width-1:0] count_reg;
  logic                 last_reg;
  logic                 accept;

  assign accept = (state_reg == ACCEPT) && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sticky
      assign sticky_next[gi] = sticky_reg[gi] | fma_exception[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = ACCEPT;
      ACCEPT:  if (in_valid)  state_next = EXEC;
      EXEC:    state_next = last_reg ? DONE : ACCEPT;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand registers only move on an accepted pair, so the FMA inputs stay quiet otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      op1_reg    <= '0;
      op2_reg    <= '0;
      op_acc_reg <= '0;
      mode_reg   <= '0;
      sticky_reg <= '0;
      count_reg  <= '0;
      last_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        acc_reg    <= init_acc;
        mode_reg   <= round_mode;
        sticky_reg <= '0;
        count_reg  <= '0;
      end
      if (accept) begin
        op1_reg    <= in_a;
        op2_reg    <= in_b;
        op_acc_reg <= acc_reg;
        last_reg   <= in_last;
      end
      if (state_reg == EXEC) begin
        acc_reg    <= fma_result;
        sticky_reg <= sticky_next;
        count_reg  <= (&count_reg) ? count_reg : count_reg + 1'b1;
      end
    end
  end

  assign busy           = (state_reg != IDLE);
  assign in_ready       = (state_reg == ACCEPT);
  assign out_valid      = (state_reg == DONE);
  assign fma_op1        = op1_reg;
  assign fma_op2        = op2_reg;
  assign fma_op_acc     = op_acc_reg;
  assign fma_round_mode = mode_reg;
  assign out_result     = acc_reg;
  assign out_exception  = sticky_reg;
  assign out_count      = count_reg;
endmodule

// File: tb/tb_fp_fma_dot_sequencer.sv
// Scoreboard bench for fp_fma_dot_sequencer with a table-driven single-precision FMA stand-in.
// A narrow element counter is used so that count saturation is reachable with a short vector.
module tb_fp_fma_dot_sequencer;
  localparam int CW = 2;
  localparam logic [4:0] FP_INEXACT  = 5'b00001;
  localparam logic [4:0] FP_OVERFLOW = 5'b00100;
  localparam logic [4:0] FP_INVALID  = 5'b10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   init_acc;
  logic [1:0]    round_mode;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a, in_b;
  logic          in_last;
  logic [31:0]   fma_op1, fma_op2, fma_op_acc;
  logic [1:0]    fma_round_mode;
  logic [31:0]   fma_result;
  logic [4:0]    fma_exception;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [4:0]    out_exception;
  logic [CW-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  typedef struct {
    logic [31:0]   res;
    logic [4:0]    exc;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  fp_fma_dot_sequencer #(.exp_width(8), .frac_width(23), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .init_acc(init_acc), .round_mode(round_mode),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .fma_op1(fma_op1), .fma_op2(fma_op2), .fma_op_acc(fma_op_acc),
    .fma_round_mode(fma_round_mode), .fma_result(fma_result), .fma_exception(fma_exception),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_exception(out_exception), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Hand-computed FMA results for every operand triple the stimulus can produce.
  function automatic logic [36:0] fma_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
    case ({a, b, c})
      96'h00000000_00000000_00000000: return {32'h00000000, 5'b0};
      96'h3F800000_40000000_00000000: return {32'h40000000, 5'b0};
      96'h40400000_3F000000_40000000: return {32'h40600000, 5'b0};
      96'h3F800000_40000000_3F800000: return {32'h40400000, 5'b0};
      96'h40400000_3F000000_40400000: return {32'h40900000, 5'b0};
      96'h7F7FFFFF_40000000_00000000: return {32'h7F800000, FP_OVERFLOW | FP_INEXACT};
      96'h3F800000_3F800000_00000000: return {32'h3F800000, 5'b0};
      96'h3F800000_3F800000_3F800000: return {32'h40000000, 5'b0};
      96'h3F800000_3F800000_40000000: return {32'h40400000, 5'b0};
      96'h3F800000_3F800000_40400000: return {32'h40800000, 5'b0};
      default:                        return {32'hDEADBEEF, FP_INVALID};
    endcase
  endfunction

  always_comb {fma_result, fma_exception} = fma_model(fma_op1, fma_op2, fma_op_acc);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  always @(posedge clk) if (!rst && in_valid && in_ready) n_acc++;

  // Monitor: every output handshake pops and checks one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(out_result), 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_result", 64'(out_result), 64'(e.res));
        chk("out_exception", 64'(out_exception), 64'(e.exc));
        chk("out_count", 64'(out_count), 64'(e.cnt));
      end
    end
  end

  task automatic push_exp(input logic [31:0] res, input logic [4:0] exc, input logic [CW-1:0] cnt);
    exp_t e;
    e.res = res; e.exc = exc; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic start_vec(input logic [31:0] init, input logic [1:0] mode);
    start = 1'b1; init_acc = init; round_mode = mode;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'h0);
  endtask

  task automatic std_pairs();
    drive_pair(32'h3F800000, 32'h40000000, 1'b0);
    drive_pair(32'h40400000, 32'h3F000000, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] pat;
    int acc0;
    rst = 1'b1; start = 1'b0; init_acc = '0; round_mode = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_fma_ops", {fma_op1, fma_op2 | fma_op_acc}, 64'h0);
    chk("rst_fma_mode", 64'(fma_round_mode), 64'h0);
    chk("rst_outputs", {out_result, 27'(out_exception), 5'(out_count)}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1*2 + 3*0.5 = 3.5, with start-to-valid latency of 2N+1
    push_exp(32'h40600000, 5'b0, CW'(2));
    start_vec(32'h0, 2'b00);
    std_pairs();
    chk("latency_not_early", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    chk("latency_valid", 64'(out_valid), 64'h1);
    wait_idle();

    // init 1.0 -> 4.5, result held under backpressure; start in DONE ignored
    out_ready = 1'b0;
    push_exp(32'h40900000, 5'b0, CW'(2));
    start_vec(32'h3F800000, 2'b00);
    std_pairs();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", 64'(out_valid), 64'h1);
      chk("hold_result", {out_result, 27'(out_exception), 5'(out_count)},
          {32'h40900000, 27'h0, 5'd2});
      start = (k == 0); init_acc = 32'h7F7FFFFF;
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_busy", 64'(busy), 64'h0);
    chk("post_hs_valid", 64'(out_valid), 64'h0);

    // overflow flag, then sticky cleared on the next vector
    push_exp(32'h7F800000, FP_OVERFLOW | FP_INEXACT, CW'(1));
    start_vec(32'h0, 2'b00);
    drive_pair(32'h7F7FFFFF, 32'h40000000, 1'b1);
    wait_idle();
    push_exp(32'h40600000, 5'b0, CW'(2));
    start_vec(32'h0, 2'b00);
    std_pairs();
    wait_idle();

    // in_valid held high across three pairs
    push_exp(32'h40400000, 5'b0, CW'(3));
    start_vec(32'h0, 2'b01);
    chk("round_mode_latched", 64'(fma_round_mode), 64'h1);
    acc0 = n_acc;
    pat = 5'b10101;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("ready_toggle", 64'(in_ready), 64'(pat[4-k]));
      if (k == 3) in_last = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_idle();
    chk("accept_count", 64'(n_acc - acc0), 64'h3);

    // four pairs saturate the narrow counter
    push_exp(32'h40800000, 5'b0, {CW{1'b1}});
    start_vec(32'h0, 2'b00);
    for (int k = 0; k < 4; k++) drive_pair(32'h3F800000, 32'h3F800000, k == 3);
    wait_idle();

    // reset during EXEC of the second of three pairs
    start_vec(32'h0, 2'b00);
    drive_pair(32'h3F800000, 32'h3F800000, 1'b0);
    drive_pair(32'h3F800000, 32'h3F800000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", {60'h0, busy, out_valid, in_ready, 1'b0}, 64'h0);
    chk("midrst_fma", 64'(fma_op1), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(32'h40600000, 5'b0, CW'(2));
    start_vec(32'h0, 2'b00);
    std_pairs();
    wait_idle();

    // in_valid in IDLE (even with start) and start in ACCEPT have no effect
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);
    push_exp(32'h40600000, 5'b0, CW'(2));
    start_vec(32'h0, 2'b00);
    in_valid = 1'b0;
    chk("idle_pair_dropped", 64'(fma_op1), 64'h40400000);
    start = 1'b1; init_acc = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_start_ignored", {62'h0, busy, in_ready}, 64'h3);
    std_pairs();
    wait_idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
